// File: rtl/mm_read_burst_core_pkg.sv
// Shared types and AXI constants for the read burst engine.
package mm_read_burst_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // AXI size code: log2 of bytes per beat
  function automatic logic [2:0] arsize_f(input int dsize);
    return 3'($clog2(dsize / 8));
  endfunction

endpackage

// File: rtl/mm_read_burst_core.sv
// AXI4 read-master burst engine: one AR per request, R beats forwarded
// through a single output register under downstream backpressure.
module mm_read_burst_core
  import mm_read_burst_core_pkg::*;
#(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE    = 4,
  parameter int ID        = 0
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 read_req,
  input  logic [ASIZE-1:0]     req_addr,
  input  logic [LSIZE-1:0]     req_len,
  output logic                 req_resp,
  output logic                 req_done,
  input  logic                 pend_in,
  output logic                 pend_out,
  input  logic                 data_ready,
  output logic [AXI_DSIZE-1:0] odata,
  output logic                 odata_vld,
  output logic                 olast,
  output logic                 err_resp,
  output logic                 err_last,
  output logic [IDSIZE-1:0]    axi_arid,
  output logic [ASIZE-1:0]     axi_araddr,
  output logic [LSIZE-1:0]     axi_arlen,
  output logic [2:0]           axi_arsize,
  output logic [1:0]           axi_arburst,
  output logic                 axi_arlock,
  output logic [3:0]           axi_arcache,
  output logic [2:0]           axi_arprot,
  output logic [3:0]           axi_arqos,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  input  logic [IDSIZE-1:0]    axi_rid,
  input  logic [AXI_DSIZE-1:0] axi_rdata,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rlast,
  input  logic                 axi_rvalid,
  output logic                 axi_rready
);

  state_t       state;
  logic [LSIZE:0] cnt;
  logic         beat;
  logic         rid_unused;

  assign axi_arid    = IDSIZE'(ID);
  assign axi_arsize  = arsize_f(AXI_DSIZE);
  assign axi_arburst = BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = CACHE_DEFAULT;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;

  // No skid buffer: the slave sees downstream readiness directly.
  assign axi_rready = (state == DATA) && data_ready;
  assign beat       = axi_rvalid && axi_rready;
  assign rid_unused = ^axi_rid;

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_resp    <= 1'b0;
      req_done    <= 1'b0;
      pend_out    <= 1'b0;
      odata       <= '0;
      odata_vld   <= 1'b0;
      olast       <= 1'b0;
      err_resp    <= 1'b0;
      err_last    <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
    end else begin
      req_resp  <= 1'b0;
      req_done  <= 1'b0;
      odata_vld <= 1'b0;
      olast     <= 1'b0;
      case (state)
        IDLE: if (read_req && !pend_in) begin
          axi_araddr  <= req_addr;
          axi_arlen   <= req_len;
          axi_arvalid <= 1'b1;
          req_resp    <= 1'b1;
          pend_out    <= 1'b1;
          err_resp    <= 1'b0;
          err_last    <= 1'b0;
          cnt         <= '0;
          state       <= ADDR;
        end
        ADDR: if (axi_arready) begin
          axi_arvalid <= 1'b0;
          state       <= DATA;
        end
        DATA: if (beat) begin
          odata     <= axi_rdata;
          odata_vld <= 1'b1;
          olast     <= axi_rlast;
          cnt       <= cnt + 1'b1;
          if (axi_rresp != RESP_OKAY) err_resp <= 1'b1;
          // rlast is authoritative for termination; a misplaced one only flags
          if (axi_rlast) begin
            if (cnt != {1'b0, axi_arlen}) err_last <= 1'b1;
            req_done <= 1'b1;
            state    <= DONE;
          end else if (cnt == {1'b0, axi_arlen}) begin
            err_last <= 1'b1;
          end
        end
        DONE: begin
          pend_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_read_burst_core.sv
// Randomized bench for mm_read_burst_core with a transaction-level slave model.
module tb_mm_read_burst_core;

  localparam int ASIZE = 29;
  localparam int LSIZE = 9;
  localparam int DW    = 256;
  localparam int IDSIZE = 4;

  logic              clock = 1'b0;
  logic              rst;
  logic              read_req;
  logic [ASIZE-1:0]  req_addr;
  logic [LSIZE-1:0]  req_len;
  logic              req_resp, req_done;
  logic              pend_in, pend_out;
  logic              data_ready;
  logic [DW-1:0]     odata;
  logic              odata_vld, olast, err_resp, err_last;
  logic [IDSIZE-1:0] axi_arid;
  logic [ASIZE-1:0]  axi_araddr;
  logic [LSIZE-1:0]  axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_arlock;
  logic [3:0]        axi_arcache;
  logic [2:0]        axi_arprot;
  logic [3:0]        axi_arqos;
  logic              axi_arvalid, axi_arready;
  logic [IDSIZE-1:0] axi_rid;
  logic [DW-1:0]     axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast, axi_rvalid, axi_rready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mm_read_burst_core #(
    .ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(DW), .IDSIZE(IDSIZE), .ID(0)
  ) dut (
    .clock(clock), .rst(rst),
    .read_req(read_req), .req_addr(req_addr), .req_len(req_len),
    .req_resp(req_resp), .req_done(req_done),
    .pend_in(pend_in), .pend_out(pend_out),
    .data_ready(data_ready), .odata(odata), .odata_vld(odata_vld), .olast(olast),
    .err_resp(err_resp), .err_last(err_last),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_resp"}, req_resp, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_pend_out"}, pend_out, 0);
    chk({tag, "_odata"}, odata, 0);
    chk({tag, "_odata_vld"}, odata_vld, 0);
    chk({tag, "_olast"}, olast, 0);
    chk({tag, "_err_resp"}, err_resp, 0);
    chk({tag, "_err_last"}, err_last, 0);
    chk({tag, "_araddr"}, axi_araddr, 0);
    chk({tag, "_arlen"}, axi_arlen, 0);
    chk({tag, "_arvalid"}, axi_arvalid, 0);
    chk({tag, "_rready"}, axi_rready, 0);
    chk({tag, "_arid"}, axi_arid, 0);
    chk({tag, "_arsize"}, axi_arsize, 5);
    chk({tag, "_arburst"}, axi_arburst, 1);
    chk({tag, "_arcache"}, axi_arcache, 3);
    chk({tag, "_arlock_prot_qos"}, {axi_arlock, axi_arprot, axi_arqos}, 0);
  endtask

  // mode 0: no stalls; 1: data_ready toggles, rvalid steady; 2: fully random.
  // last_idx: beat index the slave marks rlast; err_beat: beat with SLVERR (-1 none).
  // abort_at: assert reset once this many beats have been accepted (-1 never).
  task automatic run_burst(input logic [ASIZE-1:0] addr, input logic [LSIZE-1:0] len,
                           input int last_idx, input int err_beat,
                           input int mode, input int abort_at);
    int beat, cyc;
    bit fire, dr_t, exp_l;
    logic [DW-1:0] exp_d;
    bit exp_err_resp, exp_err_last;
    exp_err_last = (last_idx != int'(len));
    exp_err_resp = (err_beat >= 0) && (err_beat <= last_idx);

    pend_in = 0; read_req = 1; req_addr = addr; req_len = len;
    @(negedge clock);
    read_req = 0; req_addr = $urandom(); req_len = $urandom();
    chk("req_resp", req_resp, 1);
    chk("pend_out_acc", pend_out, 1);
    chk("arvalid_acc", axi_arvalid, 1);
    chk("araddr", axi_araddr, addr);
    chk("arlen", axi_arlen, len);
    chk("err_last_clr", err_last, 0);
    chk("err_resp_clr", err_resp, 0);

    cyc = 0;
    forever begin
      axi_arready = (mode != 2) || ($urandom_range(0, 2) == 0);
      axi_rvalid  = (mode == 2) && $urandom_range(0, 1);
      data_ready  = 1;
      #1 chk("rready_addr", axi_rready, 0);
      fire = axi_arready;
      @(negedge clock);
      if (fire) break;
      chk("arvalid_hold", axi_arvalid, 1);
      chk("araddr_hold", axi_araddr, addr);
      if (++cyc > 100) begin chk("ar_timeout", 1, 0); return; end
    end
    axi_arready = 0;
    chk("arvalid_drop", axi_arvalid, 0);

    beat = 0; dr_t = 1; cyc = 0;
    forever begin
      case (mode)
        0: begin axi_rvalid = 1; data_ready = 1; end
        1: begin axi_rvalid = 1; data_ready = dr_t; dr_t = !dr_t; end
        default: begin
          axi_rvalid = ($urandom_range(0, 3) != 0);
          data_ready = ($urandom_range(0, 3) != 0);
          pend_in    = $urandom_range(0, 1);
        end
      endcase
      axi_rdata = rnd_data();
      axi_rid   = $urandom();
      axi_rlast = (beat == last_idx);
      axi_rresp = (beat == err_beat) ? 2'b10 : 2'b00;
      #1 chk("rready", axi_rready, data_ready);
      fire  = axi_rvalid && data_ready;
      exp_d = axi_rdata;
      exp_l = axi_rlast;
      @(negedge clock);
      chk("odata_vld", odata_vld, fire);
      chk("pend_out_busy", pend_out, 1);
      if (fire) begin
        chk("odata", odata, exp_d);
        chk("olast", olast, exp_l);
        if (exp_l) break;
        beat++;
        if (beat == abort_at) begin
          rst = 1; axi_rvalid = 0;
          @(negedge clock);
          chk_idle_outputs("abort");
          rst = 0; pend_in = 0;
          return;
        end
      end
      if (++cyc > 400) begin chk("r_timeout", 1, 0); return; end
    end

    axi_rvalid = 0; axi_rlast = 0; pend_in = 0; data_ready = 1;
    chk("req_done", req_done, 1);
    chk("pend_out_done", pend_out, 1);
    @(negedge clock);
    chk("req_done_pulse", req_done, 0);
    chk("pend_out_rel", pend_out, 0);
    chk("odata_vld_end", odata_vld, 0);
    chk("err_resp", err_resp, exp_err_resp);
    chk("err_last", err_last, exp_err_last);
  endtask

  initial begin
    rst = 1; read_req = 0; req_addr = 0; req_len = 0; pend_in = 0; data_ready = 0;
    axi_arready = 0; axi_rid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0; axi_rvalid = 0;
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    rst = 0;
    @(negedge clock);

    run_burst(29'h1000, 9'd7, 7, -1, 0, -1);
    chk("arsize", axi_arsize, 5);
    run_burst(29'h2000, 9'd7, 7, -1, 1, -1);

    pend_in = 1; read_req = 1; req_addr = 29'h3000; req_len = 9'd4;
    repeat (10) begin
      @(negedge clock);
      chk("arb_req_resp", req_resp, 0);
      chk("arb_arvalid", axi_arvalid, 0);
      chk("arb_pend_out", pend_out, 0);
    end
    run_burst(29'h3000, 9'd4, 4, -1, 2, -1);

    run_burst(29'h4000, 9'd0, 0, 0, 0, -1);
    run_burst(29'h5000, 9'd3, 1, -1, 0, -1);
    run_burst(29'h5100, 9'd2, 4, 3, 2, -1);
    run_burst(29'h6000, 9'd7, 7, -1, 0, 3);
    run_burst(29'h7000, 9'd7, 7, -1, 0, -1);

    for (int i = 0; i < 25; i++) begin
      int len, last, eb;
      len  = $urandom_range(0, 15);
      last = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 2) : len;
      eb   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_burst(ASIZE'($urandom()), LSIZE'(len), last, eb, 2, -1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
